// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, frame width and bit-period helper for the UART receiver
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DATA_BITS = 8;
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit-period counter giving mid-bit and end-of-bit ticks
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  // free-running modulo-CLKS_PER_BIT count, restarted by the FSM at each phase change
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clear || full_tick) ? '0 : cnt + 1'b1;
  assign half_tick = cnt == W'(CLKS_PER_BIT / 2 - 1);
  assign full_tick = cnt == W'(CLKS_PER_BIT - 1);
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with 2-flop input synchronizer and one-cycle byte strobe
module uart_receiver
  import uart_pkg::*;
#(
  parameter int clk_freq  = 12000000,
  parameter int baud_rate = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 avail
);
  localparam int CLKS_PER_BIT = calc_clks_per_bit(clk_freq, baud_rate);
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_receiver: clk_freq/baud_rate must be at least 4");
    end
  endgenerate
  state_t state, nxt;
  logic sync1, rxs;
  logic [2:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic ferr, clear, shift, accept, half_tick, full_tick;
  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );
  // two-flop synchronizer, reset to the idle-high line level
  always_ff @(posedge clk or negedge rst)
    if (!rst) {rxs, sync1} <= 2'b11;
    else {rxs, sync1} <= {sync1, rxd};
  // FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  // next state and per-cycle controls; the baud counter is held clear in IDLE so START begins at zero
  always_comb begin
    nxt = state;
    clear = 1'b0;
    shift = 1'b0;
    accept = 1'b0;
    case (state)
      IDLE: begin
        clear = 1'b1;
        nxt = rxs ? IDLE : START;
      end
      START: if (half_tick) begin
        clear = 1'b1;
        nxt = rxs ? IDLE : DATA;
      end
      DATA: if (full_tick) begin
        shift = 1'b1;
        nxt = (bit_idx == 3'(DATA_BITS - 1)) ? STOP : DATA;
      end
      STOP: if (ferr) nxt = rxs ? IDLE : STOP;
      else if (full_tick) begin
        accept = rxs;
        nxt = rxs ? IDLE : STOP;
      end
      default: nxt = IDLE;
    endcase
  end
  // datapath: shift LSB first, latch the byte on a good stop bit, and remember a framing error until the line recovers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bit_idx <= '0;
      shreg <= '0;
      ferr <= 1'b0;
      data <= '0;
      avail <= 1'b0;
    end else begin
      bit_idx <= (state == IDLE) ? '0 : shift ? bit_idx + 1'b1 : bit_idx;
      if (shift) shreg <= {rxs, shreg[DATA_BITS-1:1]};
      ferr <= (state == STOP) && !rxs && (ferr || full_tick);
      avail <= accept;
      if (accept) data <= shreg;
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames at 8 clocks per bit with hand-computed expected bytes
module tb_uart_receiver;
  logic clk = 1'b0, rst = 1'b0, rxd = 1'b1;
  logic [7:0] data;
  logic avail;
  int vecs = 0, errs = 0, pulses = 0, held = 0, cyc = 0, fall_cyc = 0, lat = 0;
  logic prev = 1'b0;
  logic [7:0] got[$];
  uart_receiver #(.clk_freq(8), .baud_rate(1)) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .data(data),
    .avail(avail)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // strobe monitor on the falling edge: count pulses, log bytes, flag any strobe longer than one cycle
  always @(negedge clk) begin
    if (avail) begin
      pulses <= pulses + 1;
      got.push_back(data);
      lat <= cyc - fall_cyc;
    end
    if (avail && prev) held <= held + 1;
    prev <= avail;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    fall_cyc = cyc;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (8) @(negedge clk);
    end
    rxd = stop;
    repeat (8) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", data, 32'h00);
    chk("rst_avail", avail, 32'h0);
    rst = 1'b1;
    idle(200);
    chk("idle_pulses", pulses, 0);
    chk("idle_data", data, 32'h00);
    send(8'h55, 1'b1);
    idle(4);
    chk("f55_pulses", pulses, 1);
    chk("f55_data", data, 32'h55);
    chk("f55_latency_77_79", lat >= 77 && lat <= 79, 1);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    idle(4);
    chk("b2b_pulses", pulses, 3);
    chk("b2b_first", got[1], 32'h00);
    chk("b2b_second", got[2], 32'hFF);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    idle(30);
    chk("glitch_pulses", pulses, 3);
    send(8'hA5, 1'b1);
    idle(4);
    chk("a5_pulses", pulses, 4);
    chk("a5_data", data, 32'hA5);
    send(8'h3C, 1'b0);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    idle(20);
    chk("ferr_pulses", pulses, 4);
    chk("ferr_data", data, 32'hA5);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      repeat (8) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_data", data, 32'h00);
    chk("midrst_avail", avail, 32'h0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    idle(20);
    chk("midrst_pulses", pulses, 4);
    send(8'h81, 1'b1);
    idle(4);
    chk("f81_pulses", pulses, 5);
    chk("f81_data", data, 32'h81);
    chk("strobe_width", held, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
